// File: rtl/ppu_pkg.sv
// Shared PPU types: pixel FIFO entry, scanline width, palette lookup, PPU mode states.
package ppu_pkg;

  localparam int unsigned PPU_LINE_PX = 160;

  typedef enum logic [1:0] {
    PPU_HBLANK = 2'd0,
    PPU_VBLANK = 2'd1,
    PPU_OAM    = 2'd2,
    PPU_DRAW   = 2'd3
  } PPU_STATES_t;

  typedef struct packed {
    logic [1:0] bg_c;
    logic [1:0] ob_c;
    logic       ob_pal;
    logic       ob_prio;
    logic       ob_set;
  } ppu_px_t;

  // Map a 2-bit colour index through an 8-bit palette register.
  function automatic logic [1:0] ppu_shade(input logic [7:0] pal, input logic [1:0] c);
    logic [1:0] s;
    case (c)
      2'd0:    s = pal[1:0];
      2'd1:    s = pal[3:2];
      2'd2:    s = pal[5:4];
      default: s = pal[7:6];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ppu_obj_mixer.sv
// Overlays one sprite row onto the 8 head FIFO entries; first sprite to claim a slot wins.
// Present only when PPU_FIFO_OBJ_EN is defined.
`ifdef PPU_FIFO_OBJ_EN
module ppu_obj_mixer
  import ppu_pkg::*;
(
  input  ppu_px_t [7:0] head,
  input  logic [7:0]    obj_lo,
  input  logic [7:0]    obj_hi,
  input  logic          obj_pal,
  input  logic          obj_prio,
  output ppu_px_t [7:0] merged
);

  logic [1:0] oc [8];

  always_comb begin
    merged = head;
    for (int i = 0; i < 8; i++) begin
      oc[i] = {obj_hi[7-i], obj_lo[7-i]};
      if (oc[i] != 2'd0 && !head[i].ob_set) begin
        merged[i].ob_c    = oc[i];
        merged[i].ob_pal  = obj_pal;
        merged[i].ob_prio = obj_prio;
        merged[i].ob_set  = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/ppu_pixel_fifo.sv
// DEPTH-entry PPU pixel FIFO: tile-row push, sprite overlay, fine-scroll discard, palette resolve.
// Sprite support is compiled in with PPU_FIFO_OBJ_EN.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LINE_PX = PPU_LINE_PX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_start,
  input  logic [2:0]             scx_fine,
  input  logic [7:0]             row_lo,
  input  logic [7:0]             row_hi,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [7:0]             obj_lo,
  input  logic [7:0]             obj_hi,
  input  logic                   obj_pal,
  input  logic                   obj_prio,
  input  logic                   obj_valid,
  output logic                   obj_ready,
  input  logic                   pop_en,
  input  logic                   bg_en,
  input  logic [7:0]             bgp,
  input  logic [7:0]             obp0,
  input  logic [7:0]             obp1,
  output logic [1:0]             px_out,
  output logic                   px_valid,
  output logic [7:0]             x_count,
  output logic                   line_done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  PPU_STATES_t   state_q, state_d;
  ppu_px_t       fifo_q [DEPTH];
  ppu_px_t       fifo_d [DEPTH];
  ppu_px_t       head;
  logic [LW-1:0] level_d, base;
  logic [2:0]    disc_q, disc_d, k;
  logic [7:0]    x_count_d;
  logic [1:0]    px_out_d, shade_c, bg_c;
  logic          px_valid_d, line_done_d, row_ready_d;
  logic          push, pop, merge, active;
  ppu_px_t [7:0] merged8;

  assign head   = fifo_q[0];
  assign active = (state_q == PPU_DRAW);

`ifdef PPU_FIFO_OBJ_EN
  ppu_px_t [7:0] head8;
  logic          obj_win;

  always_comb begin
    for (int i = 0; i < 8; i++) head8[i] = fifo_q[i];
  end

  assign merge     = obj_valid && active && !line_start && (level >= LW'(8));
  assign obj_ready = merge;

  ppu_obj_mixer u_mixer (
    .head     (head8),
    .obj_lo   (obj_lo),
    .obj_hi   (obj_hi),
    .obj_pal  (obj_pal),
    .obj_prio (obj_prio),
    .merged   (merged8)
  );

  // BG colour 0 always lets the sprite through; prio only hides it behind colours 1-3.
  always_comb begin
    bg_c    = bg_en ? head.bg_c : 2'd0;
    obj_win = head.ob_set && (head.ob_c != 2'd0) && (!head.ob_prio || bg_c == 2'd0);
    shade_c = obj_win ? ppu_shade(head.ob_pal ? obp1 : obp0, head.ob_c) : ppu_shade(bgp, bg_c);
  end
`else
  logic unused_obj;

  assign merge      = 1'b0;
  assign obj_ready  = 1'b1;
  assign merged8    = '0;
  assign bg_c       = bg_en ? head.bg_c : 2'd0;
  assign shade_c    = ppu_shade(bgp, bg_c);
  assign unused_obj = ^{obj_lo, obj_hi, obj_pal, obj_prio, obj_valid, obp0, obp1,
                        head.ob_c, head.ob_pal, head.ob_prio, head.ob_set, merged8};
`endif

  // Line control: DRAW while the line is active, HBLANK once LINE_PX pixels are out.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    pop         = 1'b0;
    disc_d      = disc_q;
    x_count_d   = x_count;
    px_valid_d  = 1'b0;
    px_out_d    = px_out;
    line_done_d = 1'b0;
    case (state_q)
      PPU_DRAW: begin
        // A merge owns the head slots this cycle, so both push and pop wait.
        push = row_valid && row_ready && !merge;
        pop  = pop_en && (level != '0) && !merge;
        if (pop) begin
          if (disc_q != 3'd0) begin
            disc_d = disc_q - 3'd1;
          end else begin
            px_valid_d = 1'b1;
            px_out_d   = shade_c;
            x_count_d  = x_count + 8'd1;
            if (x_count == 8'(LINE_PX - 1)) begin
              line_done_d = 1'b1;
              state_d     = PPU_HBLANK;
            end
          end
        end
      end
      default: ;
    endcase
    if (line_start) begin
      state_d     = PPU_DRAW;
      push        = 1'b0;
      pop         = 1'b0;
      disc_d      = scx_fine;
      x_count_d   = '0;
      px_valid_d  = 1'b0;
      px_out_d    = px_out;
      line_done_d = 1'b0;
    end
  end

  // Storage update: merge, then shift on pop, then append the new row behind the survivors.
  always_comb begin
    fifo_d  = fifo_q;
    level_d = level;
    base    = level - LW'(pop);
    k       = '0;
    if (line_start) begin
      level_d = '0;
    end else begin
      if (merge) begin
        for (int i = 0; i < 8; i++) fifo_d[i] = merged8[i];
      end
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
        fifo_d[DEPTH-1] = '0;
      end
      if (push) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (LW'(j) >= base && LW'(j) < base + LW'(8)) begin
            k              = 3'(LW'(j) - base);
            fifo_d[j]      = '0;
            fifo_d[j].bg_c = {row_hi[~k], row_lo[~k]};
          end
        end
      end
      level_d = level + (push ? LW'(8) : LW'(0)) - LW'(pop);
    end
    row_ready_d = (level_d <= LW'(DEPTH - 8)) && (state_d == PPU_DRAW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PPU_HBLANK;
      level     <= '0;
      disc_q    <= '0;
      x_count   <= '0;
      px_out    <= '0;
      px_valid  <= 1'b0;
      line_done <= 1'b0;
      row_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      level     <= level_d;
      disc_q    <= disc_d;
      x_count   <= x_count_d;
      px_out    <= px_out_d;
      px_valid  <= px_valid_d;
      line_done <= line_done_d;
      row_ready <= row_ready_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Directed bench for ppu_pixel_fifo: cycle vector table plus flush, sprite, line-end and reset sequences.
module tb_ppu_pixel_fifo;
  import ppu_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start, row_valid, obj_pal, obj_prio, obj_valid, pop_en, bg_en;
  logic [2:0] scx_fine;
  logic [7:0] row_lo, row_hi, obj_lo, obj_hi, bgp, obp0, obp1;
  logic       row_ready, obj_ready, px_valid, line_done;
  logic [1:0] px_out;
  logic [7:0] x_count;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       ls;
    logic [2:0] scx;
    logic       rv;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       pop;
    logic       bgen;
    int         lvl;
    logic       rr;
    logic       pxv;
    logic [1:0] pxo;
    int         xc;
  } vec_t;

  vec_t vecs[$];

  ppu_pixel_fifo #(.DEPTH(DEPTH), .LINE_PX(PPU_LINE_PX)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .scx_fine(scx_fine),
    .row_lo(row_lo), .row_hi(row_hi), .row_valid(row_valid), .row_ready(row_ready),
    .obj_lo(obj_lo), .obj_hi(obj_hi), .obj_pal(obj_pal), .obj_prio(obj_prio),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .pop_en(pop_en), .bg_en(bg_en),
    .bgp(bgp), .obp0(obp0), .obp1(obp1), .px_out(px_out), .px_valid(px_valid),
    .x_count(x_count), .line_done(line_done), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    line_start = 1'b0; scx_fine = 3'd0; row_valid = 1'b0; row_lo = 8'h00; row_hi = 8'h00;
    obj_valid = 1'b0; obj_lo = 8'h00; obj_hi = 8'h00; obj_pal = 1'b0; obj_prio = 1'b0;
    pop_en = 1'b0; bg_en = 1'b1;
  endtask

  function automatic void add(input logic ls, input logic [2:0] scx, input logic rv,
                              input logic [7:0] lo, input logic [7:0] hi, input logic pop,
                              input logic bgen, input int lvl, input logic rr, input logic pxv,
                              input logic [1:0] pxo, input int xc);
    vec_t v;
    v.ls = ls; v.scx = scx; v.rv = rv; v.lo = lo; v.hi = hi; v.pop = pop; v.bgen = bgen;
    v.lvl = lvl; v.rr = rr; v.pxv = pxv; v.pxo = pxo; v.xc = xc;
    vecs.push_back(v);
  endfunction

  task automatic new_line(input logic [2:0] scx);
    idle_inputs();
    line_start = 1'b1; scx_fine = scx;
    step();
    line_start = 1'b0;
  endtask

  initial begin
    int pxcnt, donecnt, px_at_done;
    idle_inputs();
    bgp = 8'hE4; obp0 = 8'h04; obp1 = 8'hC0;

    // Reset values
    #22;
    check("reset_level", level, 0);
    check("reset_px_valid", px_valid, 0);
    check("reset_px_out", px_out, 0);
    check("reset_row_ready", row_ready, 0);
    check("reset_x_count", x_count, 0);
    check("reset_line_done", line_done, 0);
`ifdef PPU_FIFO_OBJ_EN
    check("reset_obj_ready", obj_ready, 0);
`else
    check("reset_obj_ready_tied", obj_ready, 1);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    pop_en = 1'b1; row_valid = 1'b1; row_lo = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_px", px_valid, 0);
      check("idle_level", level, 0);
    end
    idle_inputs();

    // Vector table: fine scroll 3, backpressure, push+pop, bg_en
    add(1, 3, 0, 8'h00, 8'h00, 0, 1,  0, 1, 0, 0, 0);
    add(0, 3, 1, 8'hFF, 8'h00, 0, 1,  8, 1, 0, 0, 0);
    add(0, 3, 1, 8'hFF, 8'h00, 0, 1, 16, 0, 0, 0, 0);
    add(0, 3, 1, 8'hFF, 8'h00, 0, 1, 16, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 15, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 14, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 13, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 8'h00, 8'h00, 1, 1, 12 - i, (12 - i) <= 8, 1, 2'd1, 1 + i);
    add(0, 0, 1, 8'h00, 8'hFF, 1, 1, 15, 0, 1, 2'd1, 6);
    for (int i = 0; i < 7; i++)
      add(0, 0, 0, 8'h00, 8'h00, 1, 1, 14 - i, (14 - i) <= 8, 1, 2'd1, 7 + i);
    add(0, 0, 0, 8'h00, 8'h00, 1, 0, 7, 1, 1, 2'd0, 14);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 6, 1, 1, 2'd2, 15);
    add(0, 0, 0, 8'h00, 8'h00, 0, 1, 6, 1, 0, 2'd0, 15);

    foreach (vecs[i]) begin
      line_start = vecs[i].ls; scx_fine = vecs[i].scx; row_valid = vecs[i].rv;
      row_lo = vecs[i].lo; row_hi = vecs[i].hi; pop_en = vecs[i].pop; bg_en = vecs[i].bgen;
      step();
      check($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d_row_ready", i), row_ready, vecs[i].rr);
      check($sformatf("vec%0d_px_valid", i), px_valid, vecs[i].pxv);
      check($sformatf("vec%0d_x_count", i), x_count, vecs[i].xc);
      if (vecs[i].pxv) check($sformatf("vec%0d_px_out", i), px_out, vecs[i].pxo);
    end
    idle_inputs();

    // Flush: line_start with a row offered at level 10 drops everything
    row_valid = 1'b1; row_lo = 8'hFF; row_hi = 8'hFF;
    step();
    row_valid = 1'b0; pop_en = 1'b1;
    repeat (4) step();
    check("flush_pre_level", level, 10);
    pop_en = 1'b0; line_start = 1'b1; row_valid = 1'b1; row_lo = 8'hFF; row_hi = 8'hFF;
    step();
    check("flush_level", level, 0);
    check("flush_x_count", x_count, 0);
    check("flush_row_ready", row_ready, 1);
    line_start = 1'b0; row_valid = 1'b0;
    step();
    check("flush_row_dropped", level, 0);
    row_valid = 1'b1; row_lo = 8'hFF; row_hi = 8'h00;
    step();
    check("flush_push_level", level, 8);
    row_valid = 1'b0; pop_en = 1'b1;
    step();
    check("flush_first_px_valid", px_valid, 1);
    check("flush_first_px_out", px_out, 1);
    idle_inputs();

`ifdef PPU_FIFO_OBJ_EN
    // Sprite behind BG colour 2; merge stalls pop and push
    new_line(3'd0);
    row_valid = 1'b1; row_lo = 8'h00; row_hi = 8'hFF;
    step();
    obj_valid = 1'b1; obj_lo = 8'hFF; obj_hi = 8'hFF; obj_prio = 1'b1; obj_pal = 1'b0;
    pop_en = 1'b1; row_lo = 8'hFF; row_hi = 8'h00;
    #1;
    check("merge_obj_ready", obj_ready, 1);
    step();
    check("merge_stall_level", level, 8);
    check("merge_no_px", px_valid, 0);
    idle_inputs();
    pop_en = 1'b1;
    step();
    check("prio_bg_px_valid", px_valid, 1);
    check("prio_bg_shade", px_out, 2);
    check("prio_level", level, 7);
    pop_en = 1'b0; obj_valid = 1'b1;
    #1;
    check("no_merge_below_8", obj_ready, 0);
    step();
    check("no_merge_level", level, 7);
    idle_inputs();

    // Sprite in front, OBP1; second sprite fills only transparent slots
    new_line(3'd0);
    row_valid = 1'b1; row_lo = 8'h00; row_hi = 8'hFF;
    step();
    row_valid = 1'b0;
    obj_valid = 1'b1; obj_lo = 8'hF0; obj_hi = 8'hF0; obj_pal = 1'b1; obj_prio = 1'b0;
    step();
    obj_lo = 8'hFF; obj_hi = 8'h00; obj_pal = 1'b0;
    step();
    idle_inputs();
    pop_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("obj_px%0d_shade", i), px_out, (i < 4) ? 3 : 1);
    end
    idle_inputs();
`else
    // Sprite inputs ignored; obj_ready always high; shade from bgp
    new_line(3'd0);
    row_valid = 1'b1; row_lo = 8'h00; row_hi = 8'hFF;
    obj_valid = 1'b1; obj_lo = 8'hFF; obj_hi = 8'hFF; obj_pal = 1'b1;
    #1;
    check("noobj_obj_ready", obj_ready, 1);
    step();
    check("noobj_level", level, 8);
    row_valid = 1'b0; pop_en = 1'b1;
    step();
    check("noobj_px_valid", px_valid, 1);
    check("noobj_shade", px_out, 2);
    idle_inputs();
`endif

    // Line end: 160 visible pixels, single line_done, then pops ignored
    new_line(3'd0);
    pxcnt = 0; donecnt = 0; px_at_done = -1;
    row_valid = 1'b1; row_lo = 8'hFF; row_hi = 8'hFF; pop_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (px_valid) pxcnt++;
      if (line_done) begin
        donecnt++;
        px_at_done = pxcnt;
      end
    end
    check("end_px_count", pxcnt, 160);
    check("end_done_count", donecnt, 1);
    check("end_done_at_px", px_at_done, 160);
    check("end_x_count", x_count, 160);
    check("end_row_ready", row_ready, 0);
    check("end_no_px", px_valid, 0);
    idle_inputs();
    new_line(3'd1);
    check("end_restart_x_count", x_count, 0);

    // Asynchronous reset in the middle of a line
    row_valid = 1'b1; row_lo = 8'hFF; row_hi = 8'h00; pop_en = 1'b1;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_px_valid", px_valid, 0);
    check("arst_px_out", px_out, 0);
    check("arst_x_count", x_count, 0);
    check("arst_row_ready", row_ready, 0);
    check("arst_line_done", line_done, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_idle_no_px", px_valid, 0);
      check("arst_idle_level", level, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_pixel_fifo.md
# ppu_pixel_fifo

Parametrised successor to the PPU background shift register: a DEPTH-entry pixel FIFO between the tile fetcher and the LCD output. It accepts whole 8-pixel tile rows, overlays sprite rows onto the head slots, and discards SCX fine-scroll pixels at line start. Each emitted pixel is resolved through BGP, OBP0 or OBP1 into a 2-bit shade. It sits inside the PPU DRAW path, replacing the fixed 8-bit shifter.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; multiple of 8, minimum 16
- LINE_PX, 160, visible pixels per scanline

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- line_start  in  1  one-cycle pulse at DRAW entry; flushes the FIFO and starts the line
- scx_fine  in  3  SCX[2:0]; sampled on line_start
- row_lo / row_hi  in  8 each  BG tile row bitplanes; bit 7 is the leftmost pixel
- row_valid  in  1  BG row offered
- row_ready  out  1  FIFO can accept 8 pixels
- obj_lo / obj_hi  in  8 each  sprite row bitplanes, already X-aligned to the head
- obj_pal  in  1  0 = OBP0, 1 = OBP1
- obj_prio  in  1  1 = sprite is behind BG colours 1-3
- obj_valid  in  1  sprite row offered
- obj_ready  out  1  one-cycle merge acknowledge
- pop_en  in  1  LCD accepts a pixel this cycle
- bg_en  in  1  LCDC[0]; when 0, BG colour is forced to 0
- bgp / obp0 / obp1  in  8 each  palette registers
- px_out  out  2  shade
- px_valid  out  1  px_out is valid
- x_count  out  8  visible pixels emitted this line
- line_done  out  1  one-cycle pulse after pixel LINE_PX-1
- level  out  $clog2(DEPTH)+1  current entry count

## Operation
- Entry fields: bg_c[1:0], ob_c[1:0], ob_pal, ob_prio, ob_set.
- Push: when row_valid && row_ready, append 8 entries, MSB first, with ob_set=0.
- row_ready = (level <= DEPTH-8) && line active.
- Pop: when pop_en && level>0 && !merging, remove the head entry.
- Discard: the first scx_fine pops of a line emit nothing and do not advance x_count.
- Merge: when obj_valid && level>=8, the merge runs in one cycle and raises obj_ready. For i=0..7, head+i takes obj colour {obj_hi[7-i],obj_lo[7-i]} only if that colour is non-zero and ob_set is 0 (first sprite wins). Pop is stalled during the merge cycle.
- Resolve: the sprite wins if ob_set && ob_c!=0 && (!ob_prio || bg_c==0).
  - Shade = pal[2c+1:2c], where pal is bgp, or obp0/obp1 selected by ob_pal.
  - When bg_en=0, bg_c is treated as 0.
- Line end: after LINE_PX visible pops, the block pulses line_done, holds row_ready=0 and ignores pops until the next line_start.
- line_start mid-line: flushes the FIFO immediately and wins over any push, pop or merge in the same cycle.

## Timing
- Reset values: level=0, px_out=0, px_valid=0, x_count=0, line_done=0, row_ready=0, obj_ready=0; line inactive.
- px_out and px_valid are registered; the pixel appears 1 cycle after its pop.
- The first push is accepted 1 cycle after line_start.
- Simultaneous push and pop in one cycle: level changes by +7.
- Sprite merge has priority over push in the same cycle; the push waits.
- level never exceeds DEPTH; a push while row_ready=0 is ignored.
- x_count saturates at LINE_PX and is cleared by line_start.

## Configuration
- PPU_FIFO_OBJ_EN defined:
  - sprite fields are stored, and merge and resolve behave as described above.
- PPU_FIFO_OBJ_EN undefined:
  - entries hold bg_c only and obj_* inputs are ignored;
  - obj_ready is tied to 1 so upstream never stalls;
  - shade always comes from bgp.

## Structure
- Shared package ppu_pkg contains:
  - ppu_px_t, the entry struct;
  - PPU_LINE_PX = 160;
  - function ppu_shade(pal, c);
  - the existing PPU_STATES_t.
- One sub-module, ppu_obj_mixer: takes 8 head entries plus the sprite row and returns the 8 merged entries. It is purely combinational and instantiated only under PPU_FIFO_OBJ_EN.

## Test plan
- Reset: hold rst_n=0 mid-line -> all outputs 0 asynchronously; after release, no px_valid until line_start.
- Fine scroll: scx_fine=3, push rows with row_lo=8'hFF, row_hi=0, bgp=8'hE4, pop_en=1 continuously -> first px_valid 4 cycles after the first pop; px_out=1.
- Full/backpressure: DEPTH=16, pop_en=0, offer 3 rows -> 2 rows accepted, level=16, row_ready=0.
- Sprite priority: bg_c=2, sprite colour 3 with obj_prio=1 -> BG shade shown; same with obj_prio=0 and obp1=8'hC0, obj_pal=1 -> px_out=3.
- Line end: stream 160 visible pixels -> line_done pulses once, x_count=160, and further pops emit no px_valid.
- Flush: line_start asserted together with row_valid at level=10 -> level=0 next cycle and the row is not stored.
